// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_arbiter
// Description : Shares the external memory bus between the CPU and the OAM
//               DMA engine. A CPU write to the DMA register starts a copy of
//               LENGTH bytes from {src,8'h00} to DEST_BASE. While the copy
//               runs the engine owns the bus and CPU accesses are blocked.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int unsigned LENGTH       = 160,
  parameter int unsigned START_DELAY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataW,
  input  logic        cpuRW,
  output logic [7:0]  cpuDataR,
  output logic [15:0] memAddress,
  input  logic [7:0]  memDataR,
  output logic [7:0]  memDataW,
  output logic        RW,
  output logic        dmaActive
);

  // Delay counter is wide enough to hold START_DELAY (minimum one bit).
  localparam int unsigned    DW         = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [DW-1:0]  DELAY_INIT = DW'(START_DELAY);
  localparam logic [7:0]     LAST_IDX   = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RD    = 2'd2,
    S_WR    = 2'd3
  } state_t;

  // With no start delay a trigger jumps straight to the first read.
  localparam state_t TRIG_STATE = (START_DELAY == 0) ? S_RD : S_START;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_src_high;
  logic [7:0]      r_idx;
  logic [DW-1:0]   r_delay_cnt;
  logic [7:0]      r_dma_data;
  logic            w_reg_hit;
  logic            w_trigger;
  logic [7:0]      w_eff_high;

  assign w_reg_hit = (cpuAddress == DMA_REG_ADDR);
  assign w_trigger = w_reg_hit & cpuRW;

  // Sources in the echo region E0..FF are folded back onto C0..DF.
  assign w_eff_high = (r_src_high >= 8'hE0) ? (r_src_high - 8'h20) : r_src_high;

  // State and transfer registers; a register write restarts from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_src_high  <= 8'h00;
      r_idx       <= 8'h00;
      r_delay_cnt <= '0;
      r_dma_data  <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_trigger) begin
        r_src_high  <= cpuDataW;
        r_idx       <= 8'h00;
        r_delay_cnt <= DELAY_INIT;
      end else begin
        case (r_state)
          S_START: r_delay_cnt <= r_delay_cnt - DW'(1);
          S_WR: begin
            r_dma_data <= memDataR;
            // Terminal check precedes the increment, so idx never wraps.
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 8'h01;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state logic and bus multiplexing.
  always_comb begin
    w_next_state = r_state;
    memAddress   = cpuAddress;
    memDataW     = cpuDataW;
    RW           = cpuRW;
    cpuDataR     = memDataR;
    dmaActive    = (r_state != S_IDLE);

    if (w_trigger) begin
      // Restart wins over every other transition, including WR-to-IDLE.
      w_next_state = TRIG_STATE;
    end else begin
      case (r_state)
        S_START: begin
          if (r_delay_cnt <= DW'(1)) begin
            w_next_state = S_RD;
          end
        end
        S_RD:    w_next_state = S_WR;
        S_WR:    w_next_state = (r_idx == LAST_IDX) ? S_IDLE : S_RD;
        default: ;
      endcase
    end

    case (r_state)
      S_RD: begin
        memAddress = {w_eff_high, r_idx};
        memDataW   = r_dma_data;
        RW         = 1'b0;
        cpuDataR   = 8'hFF;
      end
      S_WR: begin
        // Read data for the preceding RD cycle arrives during this cycle.
        memAddress = DEST_BASE + {8'h00, r_idx};
        memDataW   = memDataR;
        RW         = 1'b1;
        cpuDataR   = 8'hFF;
      end
      default: begin
        // CPU owns the bus, but the DMA register never reaches it.
        if (w_reg_hit) begin
          RW = 1'b0;
        end
      end
    endcase

    if (w_reg_hit) begin
      cpuDataR = r_src_high;
    end

    if (reset) begin
      RW = 1'b0;
    end
  end

endmodule
`default_nettype wire
